// File: rtl/ysyx_23060059_icache_ctrl.sv
// Read-only L1 instruction-cache controller: lookup, AXI-style line refill and whole-cache flush.
// Owns the tag/valid/data arrays and drives the external way-replacement unit.
module ysyx_23060059_icache_ctrl #(
    parameter int unsigned NSET       = 32,
    parameter int unsigned NWAY       = 8,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        flush_i,
    output logic        flush_busy,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [31:0] mem_araddr,
    output logic [7:0]  mem_arlen,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rlast,
    output logic [4:0]  rep_idx,
    output logic [2:0]  rep_way,
    output logic        rep_access,
    output logic        rep_invalid,
    input  logic [2:0]  rep_rway
);
    localparam int unsigned IdxW  = $clog2(NSET);
    localparam int unsigned WayW  = $clog2(NWAY);
    localparam int unsigned BeatW = $clog2(LINE_WORDS);
    localparam int unsigned OffW  = BeatW + 2;
    localparam int unsigned TagW  = 32 - IdxW - OffW;
    localparam int unsigned CntW  = IdxW + WayW;

    typedef enum logic [2:0] {StIdle, StLookup, StMissAr, StMissR, StResp, StFlush} state_e;

    state_e            state_q, state_d;
    logic              flush_pend_q, init_q, err_q, resp_err_q;
    logic [31:2]       addr_q;
    logic [WayW-1:0]   victim_q;
    logic [BeatW-1:0]  beat_q;
    logic [CntW-1:0]   cnt_q;
    logic [31:0]       resp_data_q;

    logic [NWAY-1:0]   valid_q [NSET];
    logic [TagW-1:0]   tag_q   [NSET][NWAY];
    logic [31:0]       data_q  [NSET][NWAY][LINE_WORDS];

    logic [IdxW-1:0]   set;
    logic [TagW-1:0]   tag_in;
    logic [BeatW-1:0]  word;
    logic              hit;
    logic [WayW-1:0]   hit_way;
    logic              beat_fire, last_beat, fill_done, fill_err;
    logic              unused_addr;

    assign set       = addr_q[OffW +: IdxW];
    assign tag_in    = addr_q[31 -: TagW];
    assign word      = addr_q[2 +: BeatW];
    assign beat_fire = (state_q == StMissR) && mem_rvalid;
    assign last_beat = beat_q == BeatW'(LINE_WORDS - 1);
    assign fill_done = beat_fire && last_beat;
    // rlast must coincide exactly with the final beat; any mismatch poisons the fill
    assign fill_err  = err_q || (mem_rresp != 2'b00) || (mem_rlast != last_beat);

    assign mem_araddr  = {addr_q[31:OffW], {OffW{1'b0}}};
    assign mem_arlen   = 8'(LINE_WORDS - 1);
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign flush_busy  = flush_pend_q || (state_q == StFlush);
    assign rep_idx     = (state_q == StFlush) ? cnt_q[CntW-1:WayW] : set;
    assign unused_addr = ^req_addr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < NWAY; w++) begin
            if (valid_q[set][w] && tag_q[set][w] == tag_in) begin
                hit     = 1'b1;
                hit_way = WayW'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        rep_access  = 1'b0;
        rep_invalid = 1'b0;
        rep_way     = victim_q;
        unique case (state_q)
            StIdle: begin
                req_ready = init_q && !flush_pend_q;
                if (flush_pend_q) state_d = StFlush;
                else if (req_valid && req_ready) state_d = StLookup;
            end
            StLookup: begin
                if (hit) begin
                    rep_access = 1'b1;
                    rep_way    = hit_way;
                    state_d    = StResp;
                end else begin
                    rep_way     = rep_rway;
                    rep_invalid = valid_q[set][rep_rway];
                    state_d     = StMissAr;
                end
            end
            StMissAr: begin
                mem_arvalid = 1'b1;
                if (mem_arready) state_d = StMissR;
            end
            StMissR: begin
                mem_rready = 1'b1;
                if (fill_done) begin
                    rep_access = !fill_err;
                    state_d    = StResp;
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = StIdle;
            end
            StFlush: begin
                rep_invalid = 1'b1;
                rep_way     = cnt_q[WayW-1:0];
                if (cnt_q == '1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
            init_q       <= 1'b0;
            err_q        <= 1'b0;
            resp_err_q   <= 1'b0;
            addr_q       <= '0;
            victim_q     <= '0;
            beat_q       <= '0;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            for (int s = 0; s < NSET; s++) valid_q[s] <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            // Further flush requests merge into the pending one; none can arrive mid-flush usefully
            if (state_q == StIdle && flush_pend_q) flush_pend_q <= 1'b0;
            else if (flush_i && state_q != StFlush) flush_pend_q <= 1'b1;
            unique case (state_q)
                StIdle: if (req_valid && req_ready) addr_q <= req_addr[31:2];
                StLookup: begin
                    if (hit) begin
                        resp_data_q <= data_q[set][hit_way][word];
                        resp_err_q  <= 1'b0;
                    end else begin
                        victim_q              <= rep_rway;
                        err_q                 <= 1'b0;
                        beat_q                <= '0;
                        valid_q[set][rep_rway] <= 1'b0;
                    end
                end
                StMissR: begin
                    if (beat_fire) begin
                        beat_q <= beat_q + 1'b1;
                        err_q  <= fill_err;
                        if (beat_q == word) resp_data_q <= mem_rdata;
                        if (last_beat) begin
                            resp_err_q <= fill_err;
                            if (!fill_err) valid_q[set][victim_q] <= 1'b1;
                        end
                    end
                end
                StFlush: begin
                    valid_q[cnt_q[CntW-1:WayW]][cnt_q[WayW-1:0]] <= 1'b0;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Data and tag storage is not reset; validity alone gates its use.
    always_ff @(posedge clock) begin
        if (beat_fire) data_q[set][victim_q][beat_q] <= mem_rdata;
        if (fill_done && !fill_err) tag_q[set][victim_q] <= tag_in;
    end

endmodule

// File: tb/tb_ysyx_23060059_icache_ctrl.sv
// Bench for the icache controller: memory responder, FIFO replacer and a set/way cache model.
module tb_ysyx_23060059_icache_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        flush_i = 1'b0, flush_busy;
    logic        mem_arvalid, mem_arready;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_rvalid, mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rlast;
    logic [4:0]  rep_idx;
    logic [2:0]  rep_way;
    logic        rep_access, rep_invalid;
    logic [2:0]  rep_rway;

    ysyx_23060059_icache_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .flush_i(flush_i), .flush_busy(flush_busy),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arlen(mem_arlen), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
        .rep_idx(rep_idx), .rep_way(rep_way), .rep_access(rep_access),
        .rep_invalid(rep_invalid), .rep_rway(rep_rway)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;

    // Cache model: which tag each way holds, plus a FIFO replacer advanced on fills.
    bit          mv [32][8];
    logic [22:0] mt [32][8];
    logic [2:0]  ptr [32];
    assign rep_rway = ptr[rep_idx];

    bit          err_en = 1'b0, ar_stall = 1'b0, saw_ar = 1'b0;
    logic [31:0] err_line = '0;
    int          err_beat = 0;
    logic [31:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic [31:0] exp_data = '0;
    bit          exp_err = 1'b0, exp_active = 1'b0, fl_mode = 1'b0;
    int          n_inv = 0, n_acc = 0, fl_seq = 0;
    logic [4:0]  inv_idx = '0, acc_idx = '0;
    logic [2:0]  inv_way = '0, acc_way = '0;
    logic [31:0] last_data;
    logic        last_err;
    int          last_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory slave: grants AR, then streams four beats back to back.
    initial begin
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0; mem_rlast = 1'b0;
        forever begin
            @(negedge clock);
            if (mem_arvalid && !ar_stall) begin
                mem_arready = 1'b1;
                saw_ar = 1'b1; ar_addr = mem_araddr; ar_len = mem_arlen;
                @(posedge clock); #1;
                mem_arready = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(ar_addr + 32'(b * 4));
                    mem_rresp  = (err_en && ar_addr == err_line && b == err_beat) ? 2'd2 : 2'd0;
                    mem_rlast  = (b == 3);
                    @(posedge clock); #1;
                end
                mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = '0;
            end
        end
    end

    // Per-cycle compare against the model's expectations.
    initial begin
        for (int s = 0; s < 32; s++) ptr[s] = '0;
        forever begin
            @(negedge clock);
            if (rep_access || rep_invalid)
                chk("rep_exclusive", {31'b0, rep_access && rep_invalid}, 32'd0);
            if (rep_invalid) begin
                n_inv++; inv_idx = rep_idx; inv_way = rep_way;
                if (fl_mode) begin
                    chk("flush_order", {24'b0, rep_idx, rep_way}, 32'(fl_seq % 256));
                    fl_seq++;
                end
            end
            if (rep_access) begin
                n_acc++; acc_idx = rep_idx; acc_way = rep_way;
                if (mem_rready) ptr[rep_idx] = ptr[rep_idx] + 3'd1;
            end
            if (resp_valid) begin
                chk("resp_expected", {31'b0, exp_active}, 32'd1);
                chk("resp_data", resp_data, exp_data);
                chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
                chk("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input int hold);
        int s, hw, victim, n;
        bit hit, einv, eerr;
        s = int'(a[8:4]); hit = 1'b0; hw = 0;
        for (int w = 0; w < 8; w++) if (mv[s][w] && mt[s][w] == a[31:9]) begin hit = 1'b1; hw = w; end
        victim = int'(ptr[s]);
        einv = !hit && mv[s][victim];
        eerr = !hit && err_en && ({a[31:4], 4'h0} == err_line);
        exp_data = mem_word(a); exp_err = eerr; exp_active = 1'b1;
        saw_ar = 1'b0; n_inv = 0; n_acc = 0;
        @(negedge clock);
        req_valid = 1'b1; req_addr = a; n = 0;
        while (!req_ready && n < 600) begin @(negedge clock); n++; end
        chk("req_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0; last_lat = 0;
        do begin @(negedge clock); last_lat++; end while (!resp_valid && last_lat < 100);
        chk("resp_arrives", {31'b0, resp_valid}, 32'd1);
        repeat (hold) @(negedge clock);
        last_data = resp_data; last_err = resp_err;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0; exp_active = 1'b0;
        chk("ar_issued", {31'b0, saw_ar}, {31'b0, !hit});
        chk("latency", 32'(last_lat), hit ? 32'd2 : 32'd7);
        if (!hit) begin
            chk("ar_addr", ar_addr, {a[31:4], 4'h0});
            chk("ar_len", {24'b0, ar_len}, 32'd3);
        end
        chk("n_invalid", 32'(n_inv), {31'b0, einv});
        if (einv) chk("inv_loc", {24'b0, inv_idx, inv_way}, 32'(s * 8 + victim));
        chk("n_access", 32'(n_acc), (hit || !eerr) ? 32'd1 : 32'd0);
        if (hit || !eerr) chk("acc_loc", {24'b0, acc_idx, acc_way}, 32'(s * 8 + (hit ? hw : victim)));
        if (!hit) begin
            mv[s][victim] = 1'b0;
            if (!eerr) begin mv[s][victim] = 1'b1; mt[s][victim] = a[31:9]; end
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 32; s++) for (int w = 0; w < 8; w++) mv[s][w] = 1'b0;
    endtask

    initial begin
        int n, busy, rr_bad;
        model_clear();
        repeat (3) @(negedge clock);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_arvalid", {31'b0, mem_arvalid}, 32'd0);
        chk("rst_arlen", {24'b0, mem_arlen}, 32'd3);
        chk("rst_outs", {26'b0, resp_valid, mem_rready, rep_access, rep_invalid, flush_busy,
                         resp_err}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Cold miss, then hit on the same line
        fetch(32'h8000_0004, 0);
        chk("cold_data", last_data, 32'h9357_9BDB);
        chk("cold_err", {31'b0, last_err}, 32'd0);
        chk("cold_araddr", ar_addr, 32'h8000_0000);
        chk("cold_acc_loc", {24'b0, acc_idx, acc_way}, 32'd0);
        fetch(32'h8000_000C, 0);
        chk("hit_data", last_data, 32'h9357_9BD3);
        chk("hit_latency", 32'(last_lat), 32'd2);
        chk("hit_no_ar", {31'b0, saw_ar}, 32'd0);

        // Nine tags into set 5: the ninth evicts way 0 (FIFO), old tag then misses
        for (int t = 1; t <= 9; t++) fetch(32'(t * 512 + 'h50), 0);
        chk("evict_n_inv", 32'(n_inv), 32'd1);
        chk("evict_loc", {24'b0, inv_idx, inv_way}, 32'(5 * 8 + 0));
        fetch(32'h0000_0258, 0);
        chk("evicted_misses", {31'b0, saw_ar}, 32'd1);

        // Error response on beat 1
        err_en = 1'b1; err_line = 32'h0000_1230; err_beat = 1;
        fetch(32'h0000_1234, 0);
        chk("err_flag", {31'b0, last_err}, 32'd1);
        err_en = 1'b0;
        fetch(32'h0000_1234, 0);
        chk("err_line_refetch_miss", {31'b0, saw_ar}, 32'd1);
        chk("err_line_refetch_ok", {31'b0, last_err}, 32'd0);

        // Stalled response: data stays stable and nothing new is accepted
        fetch(32'h8000_0004, 10);
        chk("stall_hit_latency", 32'(last_lat), 32'd2);

        // Two flush pulses during a refill merge into one 256-entry flush
        fork
            fetch(32'h4000_0040, 0);
            begin
                n = 0;
                while (!mem_rready && n < 50) begin @(negedge clock); n++; end
                flush_i = 1'b1; @(negedge clock); flush_i = 1'b0;
                @(negedge clock); flush_i = 1'b1; @(negedge clock); flush_i = 1'b0;
            end
        join
        fl_mode = 1'b1; fl_seq = 0; n_inv = 0; busy = 0; rr_bad = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            if (!flush_busy) break;
            busy++;
            if (req_ready) rr_bad++;
        end
        fl_mode = 1'b0;
        chk("flush_pulses", 32'(n_inv), 32'd256);
        chk("flush_busy_cycles", 32'(busy), 32'd257);
        chk("flush_req_ready_low", 32'(rr_bad), 32'd0);
        chk("flush_done_ready", {31'b0, req_ready}, 32'd1);
        model_clear();
        fetch(32'h8000_0004, 0);
        chk("post_flush_miss_a", {31'b0, saw_ar}, 32'd1);
        fetch(32'h4000_004C, 0);
        chk("post_flush_miss_b", {31'b0, saw_ar}, 32'd1);

        // Reset while waiting for AR grant
        ar_stall = 1'b1;
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h2000_0000;
        @(posedge clock); #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_arvalid && n < 10) begin @(negedge clock); n++; end
        chk("stall_arvalid", {31'b0, mem_arvalid}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_arvalid", {31'b0, mem_arvalid}, 32'd0);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b1; ar_stall = 1'b0;
        model_clear();
        @(negedge clock);
        chk("rst_mid_idle", {31'b0, req_ready}, 32'd1);
        fetch(32'h8000_0004, 0);
        chk("after_rst_miss", {31'b0, saw_ar}, 32'd1);
        chk("after_rst_data", last_data, 32'h9357_9BDB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ysyx_23060059_icache_ctrl.md
# ysyx_23060059_icache_ctrl

Read-only L1 instruction-cache controller: owns the tag/valid/data arrays (32 sets × 8 ways × 16-byte lines) and sequences lookup, miss refill over an AXI-style read channel, and whole-cache flush. It drives the way-replacement unit, `ysyx_23060059_replacer`: it reports accesses and invalidations and takes the victim way from it. It sits between IFU (request/response) and the memory arbiter (AR/R channels).

## Interface
- NSET, 32, number of sets (index = addr[8:4])
- NWAY, 8, ways per set
- LINE_WORDS, 4, 32-bit words per line (offset = addr[3:0], tag = addr[31:9], 23 bits)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  IFU fetch handshake
- req_addr  in  32  fetch address (word-aligned; addr[1:0] ignored)
- resp_valid / resp_ready  out / in  1  response handshake
- resp_data  out  32  fetched instruction word
- resp_err  out  1  qualifies resp_valid: refill got error response
- flush_i  in  1  single-cycle request to invalidate entire cache (fence.i)
- flush_busy  out  1  high while a flush is pending or in progress
- mem_arvalid / mem_arready  out / in  1  read-address handshake
- mem_araddr  out  32  line-aligned address {addr[31:4],4'h0}
- mem_arlen  out  8  constant 3 (4 beats)
- mem_rvalid / mem_rready  in / out  1  read-data handshake
- mem_rdata  in  32  beat data
- mem_rresp  in  2  nonzero = error
- mem_rlast  in  1  last beat marker
- rep_idx  out  5  set index to replacer
- rep_way  out  3  way for access/invalid
- rep_access  out  1  one-cycle pulse: way used
- rep_invalid  out  1  one-cycle pulse: way freed
- rep_rway  in  3  replacer's victim choice for rep_idx (combinational)

## Operation
- States: IDLE, LOOKUP, MISS_AR, MISS_R, RESP, FLUSH.
- IDLE: req_ready=1 unless a flush is pending. flush pending → FLUSH (takes priority over req_valid in the same cycle). Else req_valid&&req_ready → latch addr, go to LOOKUP.
- LOOKUP (one cycle): compare tag against all 8 valid ways of the set.
  - Hit: pulse rep_access (rep_way=hit way), register word addr[3:2] of that line into resp_data, resp_err=0, go to RESP.
  - Miss: latch victim=rep_rway. If victim line is valid, pulse rep_invalid for it and clear its valid bit. Go to MISS_AR.
- MISS_AR: mem_arvalid=1, address and length held stable until mem_arready, then go to MISS_R.
- MISS_R: mem_rready=1. A 2-bit beat counter writes each beat into data[set][victim][beat]. The beat whose index equals addr[3:2] is copied to resp_data. Any nonzero mem_rresp sets a sticky error. mem_rlast missing on beat 3 or early on beat <3 also sets the error. On beat 3:
  - No error: write tag, set valid, pulse rep_access(victim).
  - Error: line stays invalid and no rep_access is issued.
  - Either way, resp_err=error; go to RESP.
- RESP: resp_valid=1, data and err stable until resp_ready, then go to IDLE.
- FLUSH: 8-bit counter runs 0..255, one entry per cycle. Each cycle clears valid[cnt[7:3]][cnt[2:0]] and pulses rep_invalid with rep_idx=cnt[7:3], rep_way=cnt[2:0]. After cnt=255 → IDLE, flush_busy drops.
- flush_i outside IDLE: latched as pending; serviced after the current request completes RESP. Multiple pulses merge into one flush.
- rep_idx = cnt[7:3] in FLUSH, else latched addr[8:4]. rep_access and rep_invalid are never asserted together.

## Timing
- Reset (async assert, sync-style deassert use): state=IDLE, all valid bits=0, flush pending=0. All outputs 0 except mem_arlen=3; req_ready rises in the first cycle after deassert. Data/tag arrays are not reset.
- Hit latency: req accepted cycle 0, LOOKUP cycle 1, resp_valid cycle 2. Back-to-back throughput: one hit per 3 cycles with resp_ready=1.
- Miss: mem_arvalid asserted the cycle after LOOKUP. resp_valid asserted the cycle after the 4th accepted beat.
- Flush: exactly 256 cycles of rep_invalid. req_ready=0 from the cycle flush is pending until the cycle after cnt=255.
- Reset mid-refill: AR/R outputs drop immediately. The partially written line stays invalid; the interconnect is responsible for draining.

## Test plan
- Cold miss at 0x8000_0004: AR addr 0x8000_0000 len 3, beats A0..A3 → resp_data=A1, resp_err=0; rep_invalid not pulsed, rep_access(idx 0, victim) on beat 3.
- Re-fetch 0x8000_000C after the fill → hit, resp_valid exactly 2 cycles after accept, data=A3, no AR issued.
- Fill 9 distinct tags into set 5 with the replacer model → 9th miss pulses rep_invalid for rep_rway, and the old tag then misses.
- Error refill: mem_rresp=2 on beat 1 → resp_err=1, and a later fetch of the same line misses again.
- flush_i during MISS_R → refill completes, RESP handshakes, then 256 rep_invalid pulses. Every previous hit then misses, and req_ready=0 throughout.
- resp_ready held low 10 cycles in RESP → resp_data stable, no new req accepted. Assert reset in MISS_AR → mem_arvalid=0 the same cycle, state IDLE.
